// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage, registered, with a 2-entry skid buffer and flush.
// Optional illegal-instruction flag (illegal_o): define DECODE_ILLEGAL_CHECK_EN.
module decode_pipe #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [31:0]       insn_i,
   input  logic [AWIDTH-1:0] pc_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [31:0]       insn_o,
   output logic [6:0]        opcode_o,
   output logic [4:0]        rd_o,
   output logic [4:0]        rs1_o,
   output logic [4:0]        rs2_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [4:0]        shamt_o,
   output logic [DWIDTH-1:0] imm_o
`ifdef DECODE_ILLEGAL_CHECK_EN
   ,
   output logic              illegal_o
`endif
);

   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [31:0]       insn;
      logic [6:0]        opcode;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [4:0]        shamt;
      logic [DWIDTH-1:0] imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
      logic              illegal;
`endif
   } dec_t;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic is_r, is_ialu, is_load, is_jalr, is_s, is_b;
   logic is_lui, is_auipc, is_jal, is_sys, is_fence;
   logic is_shift;
   logic [31:0] imm32;
   dec_t dec;
   dec_t main_q;
   dec_t skid_q;
   logic main_v;
   logic skid_v;
   logic live_q;
   logic in_xfer;

   assign op = insn_i[6:0];
   assign f3 = insn_i[14:12];
   assign f7 = insn_i[31:25];

   assign is_r     = op == 7'b0110011;
   assign is_ialu  = op == 7'b0010011;
   assign is_load  = op == 7'b0000011;
   assign is_jalr  = op == 7'b1100111;
   assign is_s     = op == 7'b0100011;
   assign is_b     = op == 7'b1100011;
   assign is_lui   = op == 7'b0110111;
   assign is_auipc = op == 7'b0010111;
   assign is_jal   = op == 7'b1101111;
   assign is_sys   = op == 7'b1110011;
   assign is_fence = op == 7'b0001111;

   assign is_shift = is_ialu & (f3 == 3'b001 | f3 == 3'b101);

   always_comb begin
      imm32 = '0;
      unique case (1'b1)
         is_ialu, is_load, is_jalr, is_sys:
            imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
         is_s:
            imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
         is_b:
            imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                     insn_i[30:25], insn_i[11:8], 1'b0};
         is_lui, is_auipc:
            imm32 = {insn_i[31:12], 12'b0};
         is_jal:
            imm32 = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                     insn_i[20], insn_i[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

`ifdef DECODE_ILLEGAL_CHECK_EN
   logic known;
   logic r_bad;
   logic sh_bad;

   assign known = is_r | is_ialu | is_load | is_jalr | is_s | is_b |
                  is_lui | is_auipc | is_jal | is_sys | is_fence;

   assign r_bad = is_r &
                  ((f7 != 7'h00 & f7 != 7'h20) |
                   (f7 == 7'h20 & f3 != 3'b000 & f3 != 3'b101));

   // slli only allows funct7=0; srli/srai allow 0 or 0x20
   assign sh_bad = is_shift &
                   ((f3 == 3'b001) ? (f7 != 7'h00)
                                   : (f7 != 7'h00 & f7 != 7'h20));
`endif

   always_comb begin
      dec        = '0;
      dec.pc     = pc_i;
      dec.insn   = insn_i;
      dec.opcode = op;
      dec.funct3 = f3;
      dec.rd     = (is_s | is_b) ? 5'd0 : insn_i[11:7];
      dec.rs1    = (is_lui | is_auipc | is_jal) ? 5'd0 : insn_i[19:15];
      dec.rs2    = (is_r | is_s | is_b) ? insn_i[24:20] : 5'd0;
      dec.funct7 = (is_r | is_shift) ? f7 : 7'd0;
      dec.shamt  = is_shift ? insn_i[24:20] : 5'd0;
      dec.imm    = DWIDTH'($signed(imm32));
`ifdef DECODE_ILLEGAL_CHECK_EN
      dec.illegal = !known | (insn_i[1:0] != 2'b11) | r_bad | sh_bad;
`endif
   end

   assign ready_o = live_q & !skid_v;
   assign in_xfer = valid_i & ready_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live_q <= 1'b0;
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         live_q <= 1'b1;
         if (flush_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
         end else if (!main_v || (ready_i && !skid_v)) begin
            main_v <= in_xfer;
            if (in_xfer) main_q <= dec;
         end else if (ready_i) begin
            // skid full blocks ready_o, so no input competes here
            main_q <= skid_q;
            skid_v <= 1'b0;
         end else if (in_xfer) begin
            skid_q <= dec;
            skid_v <= 1'b1;
         end
      end
   end

   assign valid_o  = main_v;
   assign pc_o     = main_q.pc;
   assign insn_o   = main_q.insn;
   assign opcode_o = main_q.opcode;
   assign rd_o     = main_q.rd;
   assign rs1_o    = main_q.rs1;
   assign rs2_o    = main_q.rs2;
   assign funct3_o = main_q.funct3;
   assign funct7_o = main_q.funct7;
   assign shamt_o  = main_q.shamt;
   assign imm_o    = main_q.imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
   assign illegal_o = main_q.illegal;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed and randomized
// checks of decode_pipe vs a 2-deep model.
module tb_decode_pipe;
  localparam int DW = 32;
  localparam int AW = 32;

  localparam logic [6:0] OPS [11] = '{
    7'b0110011, 7'b0010011, 7'b0000011,
    7'b1100111, 7'b0100011, 7'b1100011,
    7'b0110111, 7'b0010111, 7'b1101111,
    7'b1110011, 7'b0001111
  };

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   insn;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [4:0]    shamt;
    logic [DW-1:0] imm;
    logic          ill;
  } out_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [31:0]   insn_i;
  logic [AW-1:0] pc_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [AW-1:0] pc_o;
  logic [31:0]   insn_o;
  logic [6:0]    opcode_o;
  logic [4:0]    rd_o;
  logic [4:0]    rs1_o;
  logic [4:0]    rs2_o;
  logic [2:0]    funct3_o;
  logic [6:0]    funct7_o;
  logic [4:0]    shamt_o;
  logic [DW-1:0] imm_o;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic          illegal_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_pipe #(
    .DWIDTH(DW),
    .AWIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .insn_i(insn_i),
    .pc_i(pc_i),
    .flush_i(flush_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .pc_o(pc_o),
    .insn_o(insn_o),
    .opcode_o(opcode_o),
    .rd_o(rd_o),
    .rs1_o(rs1_o),
    .rs2_o(rs2_o),
    .funct3_o(funct3_o),
    .funct7_o(funct7_o),
    .shamt_o(shamt_o),
    .imm_o(imm_o)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    .illegal_o(illegal_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t sample();
    out_t g;
    g.pc     = pc_o;
    g.insn   = insn_o;
    g.opcode = opcode_o;
    g.rd     = rd_o;
    g.rs1    = rs1_o;
    g.rs2    = rs2_o;
    g.f3     = funct3_o;
    g.f7     = funct7_o;
    g.shamt  = shamt_o;
    g.imm    = imm_o;
    g.ill    = 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
    g.ill    = illegal_o;
`endif
    return g;
  endfunction

  function automatic out_t ref_decode(
    logic [31:0] insn,
    logic [AW-1:0] pc
  );
    out_t e;
    int imm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit shift;
    e = '0;
    op = insn[6:0];
    f3 = insn[14:12];
    f7 = insn[31:25];
    e.pc = pc;
    e.insn = insn;
    e.opcode = op;
    e.f3 = f3;
    e.rd = insn[11:7];
    e.rs1 = insn[19:15];
    imm = 0;
    shift = (op == 7'b0010011) &&
            (f3 == 3'd1 || f3 == 3'd5);
    case (op)
      7'b0110011: begin
        e.rs2 = insn[24:20];
        e.f7 = f7;
        e.ill = !(f7 == 7'h00 ||
                  (f7 == 7'h20 &&
                   (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        imm = $signed(insn) >>> 20;
        if (shift) begin
          e.f7 = f7;
          e.shamt = insn[24:20];
          e.ill = (f3 == 3'd1) ?
                  (f7 != 7'h00) :
                  !(f7 == 7'h00 || f7 == 7'h20);
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011:
        imm = $signed(insn) >>> 20;
      7'b0100011: begin
        e.rd = 5'd0;
        e.rs2 = insn[24:20];
        imm = int'($signed(insn) >>> 25) * 32 +
              int'(insn[11:7]);
      end
      7'b1100011: begin
        e.rd = 5'd0;
        e.rs2 = insn[24:20];
        imm = (insn[31] ? -4096 : 0) +
              int'(insn[7]) * 2048 +
              int'(insn[30:25]) * 32 +
              int'(insn[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        e.rs1 = 5'd0;
        imm = insn & 32'hFFFFF000;
      end
      7'b1101111: begin
        e.rs1 = 5'd0;
        imm = (insn[31] ? -(1 << 20) : 0) +
              int'(insn[19:12]) * 4096 +
              int'(insn[20]) * 2048 +
              int'(insn[30:21]) * 2;
      end
      7'b0001111: ;
      default: e.ill = 1'b1;
    endcase
    e.imm = DW'(imm);
`ifndef DECODE_ILLEGAL_CHECK_EN
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) w[6:0] = OPS[k];
    if ($urandom_range(0, 1) == 1)
      w[31:25] = ($urandom_range(0, 1) == 1) ?
                 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    insn_i = '0;
    pc_i = '0;
    #3;
    checks++;
    if ({valid_o, ready_o, sample()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {valid_o, ready_o, sample()});
    end
    tick();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_held got=%b",
               ready_o);
    end
    #4 rst = 1'b1;
    #2;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b",
               ready_o);
    end
    tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release %b%b",
               ready_o, valid_o);
    end
  endtask

  task automatic test_fields();
    logic [31:0] ins [5] = '{
      32'hFFF10093, 32'h00532423, 32'hFE208EE3,
      32'h123451B7, 32'h4032D213};
    logic [4:0] erd [5] =
      '{5'd1, 5'd0, 5'd0, 5'd3, 5'd4};
    logic [4:0] er1 [5] =
      '{5'd2, 5'd6, 5'd1, 5'd0, 5'd5};
    logic [4:0] er2 [5] =
      '{5'd0, 5'd5, 5'd2, 5'd0, 5'd0};
    logic [2:0] ef3 [5] =
      '{3'd0, 3'd2, 3'd0, 3'd5, 3'd5};
    logic [6:0] ef7 [5] =
      '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
    logic [4:0] esh [5] =
      '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
    logic [31:0] eim [5] = '{
      32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC,
      32'h12345000, 32'h403};
    logic [63:0] got;
    logic [63:0] want;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1;
      insn_i = ins[k];
      pc_i = 32'h100 + 32'(k * 4);
      tick();
      got = {14'd0, valid_o, rd_o, rs1_o,
             rs2_o, funct3_o, funct7_o,
             shamt_o, imm_o};
      want = {14'd0, 1'b1, erd[k], er1[k],
              er2[k], ef3[k], ef7[k],
              esh[k], eim[k]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fields_%0d got=%h want=%h",
                 k, got, want);
      end
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fields_idle got=%b",
               valid_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i = 32'h00100093;
    tick();
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h00100093 ||
        ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_a got=%b %h %b",
               valid_o, insn_o, ready_o);
    end
    insn_i = 32'h00200113;
    tick();
    checks++;
    if (insn_o !== 32'h00100093 ||
        ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_b got=%h %b",
               insn_o, ready_o);
    end
    insn_i = 32'h00300193;
    tick();
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h00100093 ||
        ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got=%b %h %b",
               valid_o, insn_o, ready_o);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h00200113) begin
      errors++;
      $display("FAIL bp_out_b got=%b %h",
               valid_o, insn_o);
    end
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h00300193) begin
      errors++;
      $display("FAIL bp_out_c got=%b %h",
               valid_o, insn_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained got=%b",
               valid_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i = 32'h00A00513;
    tick();
    insn_i = 32'h00B00593;
    tick();
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_full got=%b",
               ready_o);
    end
    flush_i = 1'b1;
    insn_i = 32'h00C00613;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 ||
        ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear got=%b%b",
               valid_o, ready_o);
    end
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost_%0d %b %h",
                 k, valid_o, insn_o);
      end
    end
    ready_i = 1'b0;
    valid_i = 1'b1;
    insn_i = 32'h00D00693;
    tick();
    flush_i = 1'b1;
    insn_i = 32'h00E00713;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_drop %b %h",
               valid_o, insn_o);
    end
    ready_i = 1'b1;
    valid_i = 1'b1;
    insn_i = 32'h00F00793;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h00F00793) begin
      errors++;
      $display("FAIL flush_resume got=%b %h",
               valid_o, insn_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    insn_i = 32'h01100813;
    tick();
    insn_i = 32'h01200893;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, ready_o, sample()} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h",
               {valid_o, ready_o, sample()});
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if ({valid_o, ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_hold %b%b",
               valid_o, ready_o);
    end
    #3 rst = 1'b1;
    tick();
    checks++;
    if (ready_o !== 1'b1 ||
        valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_release got=%b%b",
               ready_o, valid_o);
    end
    valid_i = 1'b1;
    insn_i = 32'h01300913;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 ||
        insn_o !== 32'h01300913) begin
      errors++;
      $display("FAIL async_first got=%b %h",
               valid_o, insn_o);
    end
    tick();
  endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
  task automatic test_illegal();
    logic [31:0] ins [6] = '{
      32'h0000007F, 32'hFFF10093,
      32'h40001033, 32'h00000033,
      32'h40001013, 32'h4032D213};
    logic ei [6] =
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      valid_i = 1'b1;
      insn_i = ins[k];
      tick();
      checks++;
      if (valid_o !== 1'b1 ||
          illegal_o !== ei[k]) begin
        errors++;
        $display("FAIL illegal_%0d got=%b want=%b",
                 k, illegal_o, ei[k]);
      end
    end
    valid_i = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    out_t q[$];
    out_t got;
    out_t prev;
    bit acc;
    prev = sample();
    for (int n = 0; n < 800; n++) begin
      got = sample();
      checks++;
      if (q.size() == 0) begin
        if (valid_o !== 1'b0 || got !== prev) begin
          errors++;
          $display("FAIL rand_idle_%0d %b %h %h",
                   n, valid_o, got, prev);
        end
      end else if (valid_o !== 1'b1 ||
                   got !== q[0]) begin
        errors++;
        $display("FAIL rand_data_%0d %b %h %h",
                 n, valid_o, got, q[0]);
      end
      checks++;
      if (ready_o !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rand_ready_%0d got=%b",
                 n, ready_o);
      end
      prev = got;
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 2) != 0;
      flush_i = $urandom_range(0, 19) == 0;
      insn_i = rand_insn();
      pc_i = $urandom;
      if (flush_i) begin
        q.delete();
      end else begin
        acc = valid_i && q.size() < 2;
        if (q.size() > 0 && ready_i)
          void'(q.pop_front());
        if (acc)
          q.push_back(ref_decode(insn_i, pc_i));
      end
      tick();
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fields();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef DECODE_ILLEGAL_CHECK_EN
    test_illegal();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
